// File: rtl/mic1_regbank_memctl_if.sv
// Memory-side bus of the MIC-1 register bank: RAM read/write port and ROM fetch port.
// The register bank is the master; the RAM/ROM wrapper is the slave.
interface mic1_regbank_memctl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int MBR_W  = 8
);
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_rd;
  logic              ram_wr;
  logic [DATA_W-1:0] ram_rdata;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_rd;
  logic [MBR_W-1:0]  rom_rdata;

  modport master (
    output ram_addr, ram_wdata, ram_rd, ram_wr, rom_addr, rom_rd,
    input  ram_rdata, rom_rdata
  );

  modport slave (
    input  ram_addr, ram_wdata, ram_rd, ram_wr, rom_addr, rom_rd,
    output ram_rdata, rom_rdata
  );
endinterface

// File: rtl/mic1_regbank_memctl.sv
// MIC-1 register bank with A/B bus drive and fixed-latency RAM/ROM ports.
// Optional performance counters are enabled by defining MIC1_REGBANK_PERF_EN.
module mic1_regbank_memctl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MBR_W   = 8,
  parameter int MEM_LAT = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     c_bus,
  input  logic [8:0]            c_en,
  input  logic [3:0]            b_sel,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  input  logic                  mem_fetch,
  mic1_regbank_memctl_if.master mem,
  output logic [DATA_W-1:0]     a_bus,
  output logic [DATA_W-1:0]     b_bus,
  output logic [DATA_W-1:0]     mar,
  output logic [DATA_W-1:0]     mdr,
  output logic [DATA_W-1:0]     pc,
  output logic                  stall,
  output logic                  proto_err,
  output logic [31:0]           perf_stall,
  output logic [31:0]           perf_mem
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("MEM_LAT must be in 1..15");
  end
  if (MBR_W >= DATA_W) begin : g_bad_mbr_w
    $error("MBR_W must be less than DATA_W");
  end
  if (ADDR_W > DATA_W) begin : g_bad_addr_w
    $error("ADDR_W must not exceed DATA_W");
  end

  localparam logic [3:0]  LAT   = 4'(MEM_LAT);
  localparam int unsigned EXT_W = DATA_W - MBR_W;

  logic [DATA_W-1:0] h_q, h_d, opc_q, opc_d, tos_q, tos_d, cpp_q, cpp_d;
  logic [DATA_W-1:0] lv_q, lv_d, sp_q, sp_d, pc_q, pc_d, mdr_q, mdr_d, mar_q, mar_d;
  logic [MBR_W-1:0]  mbr_q, mbr_d;
  logic [3:0]        rcnt_q, rcnt_d, fcnt_q, fcnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              proto_err_q, proto_err_d;

  logic ram_req, ram_busy, rom_busy, ram_accept, rom_accept;
  logic ram_stall, rom_stall, ram_capture, rom_capture;

  // NOTE: every variable assigned in always_comb gets a value on every path
  // (here unconditionally) so no latch is inferred.
  always_comb begin
    ram_req     = mem_rd ^ mem_wr;
    ram_busy    = rcnt_q > 4'd1;
    rom_busy    = fcnt_q > 4'd1;
    ram_accept  = ram_req && !ram_busy;
    rom_accept  = mem_fetch && !rom_busy;
    ram_stall   = ram_req && ram_busy;
    rom_stall   = mem_fetch && rom_busy;
    ram_capture = rd_pend_q && (rcnt_q == 4'd1);
    rom_capture = fcnt_q == 4'd1;
  end

  always_comb begin
    h_d   = c_en[8] ? c_bus : h_q;
    opc_d = c_en[7] ? c_bus : opc_q;
    tos_d = c_en[6] ? c_bus : tos_q;
    cpp_d = c_en[5] ? c_bus : cpp_q;
    lv_d  = c_en[4] ? c_bus : lv_q;
    sp_d  = c_en[3] ? c_bus : sp_q;
    pc_d  = c_en[2] ? c_bus : pc_q;
    mar_d = c_en[0] ? c_bus : mar_q;
    // A landing read owns MDR even if the microinstruction also writes it.
    mdr_d = ram_capture ? mem.ram_rdata : (c_en[1] ? c_bus : mdr_q);
    mbr_d = rom_capture ? mem.rom_rdata : mbr_q;

    // A new command reloads the counter, which also covers the rcnt == 1 hand-over.
    rcnt_d    = ram_accept ? LAT : ((rcnt_q != 4'd0) ? rcnt_q - 4'd1 : 4'd0);
    fcnt_d    = rom_accept ? LAT : ((fcnt_q != 4'd0) ? fcnt_q - 4'd1 : 4'd0);
    rd_pend_d = ram_accept ? mem_rd : ((rcnt_q == 4'd1) ? 1'b0 : rd_pend_q);

    proto_err_d = mem_rd & mem_wr;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      h_q         <= '0;
      opc_q       <= '0;
      tos_q       <= '0;
      cpp_q       <= '0;
      lv_q        <= '0;
      sp_q        <= '0;
      pc_q        <= '0;
      mdr_q       <= '0;
      mar_q       <= '0;
      mbr_q       <= '0;
      rcnt_q      <= '0;
      fcnt_q      <= '0;
      rd_pend_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      h_q         <= h_d;
      opc_q       <= opc_d;
      tos_q       <= tos_d;
      cpp_q       <= cpp_d;
      lv_q        <= lv_d;
      sp_q        <= sp_d;
      pc_q        <= pc_d;
      mdr_q       <= mdr_d;
      mar_q       <= mar_d;
      mbr_q       <= mbr_d;
      rcnt_q      <= rcnt_d;
      fcnt_q      <= fcnt_d;
      rd_pend_q   <= rd_pend_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    case (b_sel)
      4'd0:    b_bus = mdr_q;
      4'd1:    b_bus = pc_q;
      4'd2:    b_bus = {{EXT_W{mbr_q[MBR_W-1]}}, mbr_q};
      4'd3:    b_bus = {{EXT_W{1'b0}}, mbr_q};
      4'd4:    b_bus = sp_q;
      4'd5:    b_bus = lv_q;
      4'd6:    b_bus = cpp_q;
      4'd7:    b_bus = tos_q;
      4'd8:    b_bus = opc_q;
      default: b_bus = '0;
    endcase
  end

  assign a_bus     = h_q;
  assign mar       = mar_q;
  assign mdr       = mdr_q;
  assign pc        = pc_q;
  assign stall     = ram_stall | rom_stall;
  assign proto_err = proto_err_q;

  assign mem.ram_addr  = mar_q[ADDR_W-1:0];
  assign mem.ram_wdata = mdr_q;
  assign mem.ram_rd    = ram_accept & mem_rd;
  assign mem.ram_wr    = ram_accept & mem_wr;
  assign mem.rom_addr  = pc_q[ADDR_W-1:0];
  assign mem.rom_rd    = rom_accept;

`ifdef MIC1_REGBANK_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d, perf_mem_q, perf_mem_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {31'd0, stall};
    perf_mem_d   = perf_mem_q + {31'd0, ram_accept} + {31'd0, rom_accept};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_mem_q   <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_mem_q   <= perf_mem_d;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_mem   = perf_mem_q;
`else
  assign perf_stall = '0;
  assign perf_mem   = '0;
`endif

endmodule

// File: tb/tb_mic1_regbank_memctl.sv
// Scoreboard bench for mic1_regbank_memctl: three instances (MEM_LAT 1, 3, 4) share stimulus;
// expectations are queued with a target cycle and checked by an independent monitor.
module tb_mic1_regbank_memctl;

  localparam int N_DUT = 3;
  localparam int D1 = 0;
  localparam int D3 = 1;
  localparam int D4 = 2;
`ifdef MIC1_REGBANK_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef enum int {
    S_MDR, S_MAR, S_PC, S_ABUS, S_BBUS, S_RAM_RD, S_RAM_WR, S_RAM_ADDR, S_RAM_WDATA,
    S_ROM_RD, S_ROM_ADDR, S_STALL, S_PERR, S_PERF_STALL, S_PERF_MEM
  } sig_e;

  typedef struct {
    int          cyc;
    int          dut;
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] c_bus = '0;
  logic [8:0]  c_en = '0;
  logic [3:0]  b_sel = '0;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic        mem_fetch = 1'b0;
  logic [31:0] ram_rdata = '0;
  logic [7:0]  rom_rdata = '0;

  logic [31:0] a_bus_w [N_DUT];
  logic [31:0] b_bus_w [N_DUT];
  logic [31:0] mar_w [N_DUT];
  logic [31:0] mdr_w [N_DUT];
  logic [31:0] pc_w [N_DUT];
  logic [31:0] ram_addr_w [N_DUT];
  logic [31:0] ram_wdata_w [N_DUT];
  logic [31:0] rom_addr_w [N_DUT];
  logic [31:0] perf_stall_w [N_DUT];
  logic [31:0] perf_mem_w [N_DUT];
  logic        ram_rd_w [N_DUT];
  logic        ram_wr_w [N_DUT];
  logic        rom_rd_w [N_DUT];
  logic        stall_w [N_DUT];
  logic        perr_w [N_DUT];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit done = 1'b0;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    mic1_regbank_memctl_if mem_if ();

    mic1_regbank_memctl #(
      .MEM_LAT((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .clock      (clock),
      .reset      (reset),
      .c_bus      (c_bus),
      .c_en       (c_en),
      .b_sel      (b_sel),
      .mem_rd     (mem_rd),
      .mem_wr     (mem_wr),
      .mem_fetch  (mem_fetch),
      .mem        (mem_if),
      .a_bus      (a_bus_w[g]),
      .b_bus      (b_bus_w[g]),
      .mar        (mar_w[g]),
      .mdr        (mdr_w[g]),
      .pc         (pc_w[g]),
      .stall      (stall_w[g]),
      .proto_err  (perr_w[g]),
      .perf_stall (perf_stall_w[g]),
      .perf_mem   (perf_mem_w[g])
    );

    assign mem_if.ram_rdata = ram_rdata;
    assign mem_if.rom_rdata = rom_rdata;
    assign ram_addr_w[g]    = mem_if.ram_addr;
    assign ram_wdata_w[g]   = mem_if.ram_wdata;
    assign ram_rd_w[g]      = mem_if.ram_rd;
    assign ram_wr_w[g]      = mem_if.ram_wr;
    assign rom_addr_w[g]    = mem_if.rom_addr;
    assign rom_rd_w[g]      = mem_if.rom_rd;
  end

  initial forever #5 clock = ~clock;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  function automatic logic [31:0] get_sig(int d, sig_e s);
    case (s)
      S_MDR:        return mdr_w[d];
      S_MAR:        return mar_w[d];
      S_PC:         return pc_w[d];
      S_ABUS:       return a_bus_w[d];
      S_BBUS:       return b_bus_w[d];
      S_RAM_RD:     return {31'd0, ram_rd_w[d]};
      S_RAM_WR:     return {31'd0, ram_wr_w[d]};
      S_RAM_ADDR:   return ram_addr_w[d];
      S_RAM_WDATA:  return ram_wdata_w[d];
      S_ROM_RD:     return {31'd0, rom_rd_w[d]};
      S_ROM_ADDR:   return rom_addr_w[d];
      S_STALL:      return {31'd0, stall_w[d]};
      S_PERR:       return {31'd0, perr_w[d]};
      S_PERF_STALL: return perf_stall_w[d];
      default:      return perf_mem_w[d];
    endcase
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    c_bus     = '0;
    c_en      = '0;
    b_sel     = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_fetch = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Queue an expectation for the cycle 'off' cycles after the current one, kept sorted.
  task automatic expect_at(int off, int dut, sig_e sig, logic [31:0] val, string name);
    exp_t e;
    int   i;
    e.cyc  = cyc + off;
    e.dut  = dut;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    i = exp_q.size();
    while (i > 0 && exp_q[i-1].cyc > e.cyc) i--;
    exp_q.insert(i, e);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clock);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        n_checks++;
        if (e.cyc < cyc) begin
          n_fail++;
          $display("FAIL %s dut%0d: expectation for cycle %0d missed (now %0d)",
                   e.name, e.dut, e.cyc, cyc);
        end else begin
          act = get_sig(e.dut, e.sig);
          if (act !== e.val) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h",
                     e.name, e.dut, cyc, act, e.val);
          end
        end
      end
      if (done) begin
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_checks++;
          n_fail++;
          $display("FAIL %s dut%0d: expectation for cycle %0d never checked", e.name, e.dut, e.cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: bench did not complete, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [31:0] b_exp [16];
    b_exp = '{32'h101, 32'h102, 32'hFFFF_FF80, 32'h0000_0080, 32'h103, 32'h104, 32'h105,
              32'h106, 32'h107, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    // Reset state on every instance.
    do_reset();
    for (int d = 0; d < N_DUT; d++) begin
      expect_at(0, d, S_MDR, 32'h0, "rst_mdr");
      expect_at(0, d, S_MAR, 32'h0, "rst_mar");
      expect_at(0, d, S_PC, 32'h0, "rst_pc");
      expect_at(0, d, S_ABUS, 32'h0, "rst_abus");
      expect_at(0, d, S_BBUS, 32'h0, "rst_bbus");
      expect_at(0, d, S_STALL, 32'h0, "rst_stall");
      expect_at(0, d, S_PERR, 32'h0, "rst_perr");
      expect_at(0, d, S_PERF_STALL, 32'h0, "rst_perf_stall");
      expect_at(0, d, S_PERF_MEM, 32'h0, "rst_perf_mem");
    end
    step();

    // Reset while a MEM_LAT=3 read is in flight: the capture must never land.
    do_reset();
    c_bus = 32'h10; c_en = 9'h001;
    step(); idle();
    mem_rd = 1'b1; ram_rdata = 32'hCAFE_F00D;
    expect_at(0, D3, S_RAM_RD, 32'h1, "midrd_issue");
    expect_at(0, D3, S_RAM_ADDR, 32'h10, "midrd_addr");
    step();
    mem_rd = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    expect_at(0, D3, S_MAR, 32'h0, "midrd_mar_cleared");
    for (int k = 0; k < 6; k++) expect_at(k, D3, S_MDR, 32'h0, $sformatf("midrd_no_land%0d", k));
    repeat (6) step();

    // Fetch MBR=0x80, load every register with a distinct value, then sweep b_sel.
    do_reset();
    mem_fetch = 1'b1; rom_rdata = 8'h80;
    expect_at(0, D1, S_ROM_RD, 32'h1, "fetch_issue");
    expect_at(0, D1, S_ROM_ADDR, 32'h0, "fetch_addr");
    step(); mem_fetch = 1'b0;
    step();
    for (int i = 0; i < 9; i++) begin
      c_en  = 9'(1 << i);
      c_bus = 32'h100 + 32'(i);
      step();
    end
    idle();
    expect_at(0, D1, S_ABUS, 32'h108, "abus_h");
    expect_at(0, D1, S_PC, 32'h102, "pc_tap");
    expect_at(0, D1, S_MAR, 32'h100, "mar_tap");
    for (int s = 0; s < 16; s++) begin
      b_sel = 4'(s);
      expect_at(0, D1, S_BBUS, b_exp[s], $sformatf("bsel%0d", s));
      step();
    end
    idle();

    // Read latency: MEM_LAT=1 lands two cycles after issue is visible, MEM_LAT=4 five.
    do_reset();
    c_bus = 32'h20; c_en = 9'h001;
    step(); idle();
    mem_rd = 1'b1; ram_rdata = 32'hDEAD_BEEF;
    expect_at(0, D1, S_RAM_RD, 32'h1, "lat1_rd");
    expect_at(0, D1, S_RAM_ADDR, 32'h20, "lat1_addr");
    expect_at(0, D1, S_MAR, 32'h20, "lat1_mar");
    expect_at(1, D1, S_RAM_RD, 32'h0, "lat1_rd_once");
    expect_at(1, D1, S_MDR, 32'h0, "lat1_mdr_early");
    expect_at(2, D1, S_MDR, 32'hDEAD_BEEF, "lat1_mdr");
    expect_at(0, D4, S_RAM_RD, 32'h1, "lat4_rd");
    expect_at(4, D4, S_MDR, 32'h0, "lat4_mdr_early");
    expect_at(5, D4, S_MDR, 32'hDEAD_BEEF, "lat4_mdr");
    step(); mem_rd = 1'b0;
    repeat (6) step();

    // MEM_LAT=3: read plus fetch, then a write that stalls until rcnt == 1.
    do_reset();
    c_bus = 32'h30; c_en = 9'h001;
    step(); idle();
    mem_rd = 1'b1; mem_fetch = 1'b1; ram_rdata = 32'h1111_2222;
    expect_at(0, D3, S_RAM_RD, 32'h1, "b2b_rd_issue");
    expect_at(0, D3, S_ROM_RD, 32'h1, "b2b_fetch_issue");
    expect_at(0, D3, S_STALL, 32'h0, "b2b_rd_nostall");
    step();
    mem_rd = 1'b0; mem_fetch = 1'b0; mem_wr = 1'b1;
    expect_at(0, D3, S_STALL, 32'h1, "b2b_stall1");
    expect_at(0, D3, S_RAM_WR, 32'h0, "b2b_wr_held1");
    step();
    expect_at(0, D3, S_STALL, 32'h1, "b2b_stall2");
    expect_at(0, D3, S_RAM_WR, 32'h0, "b2b_wr_held2");
    step();
    expect_at(0, D3, S_STALL, 32'h0, "b2b_go_nostall");
    expect_at(0, D3, S_RAM_WR, 32'h1, "b2b_wr_issue");
    expect_at(0, D3, S_RAM_ADDR, 32'h30, "b2b_wr_addr");
    expect_at(0, D3, S_RAM_WDATA, 32'h0, "b2b_wdata_pre_capture");
    expect_at(0, D3, S_PERF_STALL, PERF ? 32'd2 : 32'd0, "perf_stall");
    expect_at(0, D3, S_PERF_MEM, PERF ? 32'd2 : 32'd0, "perf_mem");
    step();
    mem_wr = 1'b0; ram_rdata = 32'h9999_9999;
    expect_at(0, D3, S_MDR, 32'h1111_2222, "b2b_rd_land");
    expect_at(0, D3, S_PERF_MEM, PERF ? 32'd3 : 32'd0, "perf_mem_wr");
    expect_at(4, D3, S_MDR, 32'h1111_2222, "b2b_wr_no_capture");
    repeat (5) step();

    // Read capture beats a same-edge C write to MDR; concurrent fetch does not stall.
    do_reset();
    c_bus = 32'h40; c_en = 9'h001;
    step();
    c_bus = 32'h7; c_en = 9'h004;
    step(); idle();
    mem_rd = 1'b1; mem_fetch = 1'b1; ram_rdata = 32'hA5A5_A5A5; rom_rdata = 8'h5A;
    expect_at(0, D1, S_STALL, 32'h0, "ovl_nostall");
    expect_at(0, D1, S_RAM_RD, 32'h1, "ovl_ram_rd");
    expect_at(0, D1, S_ROM_RD, 32'h1, "ovl_rom_rd");
    expect_at(0, D1, S_ROM_ADDR, 32'h7, "ovl_rom_addr");
    expect_at(0, D1, S_PC, 32'h7, "ovl_pc");
    step();
    mem_rd = 1'b0; mem_fetch = 1'b0; c_en = 9'h002; c_bus = 32'h1234;
    step(); idle();
    b_sel = 4'd3;
    expect_at(0, D1, S_MDR, 32'hA5A5_A5A5, "prio_mdr");
    expect_at(0, D1, S_BBUS, 32'h5A, "ovl_mbr");
    step();
    b_sel = 4'd0; c_en = 9'h002; c_bus = 32'h1234;
    step(); idle();
    expect_at(0, D1, S_MDR, 32'h1234, "cwr_mdr");
    step();

    // Both RAM commands at once: nothing issued, no stall, one-cycle proto_err.
    do_reset();
    mem_rd = 1'b1; mem_wr = 1'b1;
    expect_at(0, D1, S_RAM_RD, 32'h0, "perr_no_rd");
    expect_at(0, D1, S_RAM_WR, 32'h0, "perr_no_wr");
    expect_at(0, D1, S_STALL, 32'h0, "perr_no_stall");
    expect_at(0, D1, S_PERR, 32'h0, "perr_not_yet");
    step(); idle();
    expect_at(0, D1, S_PERR, 32'h1, "perr_pulse");
    expect_at(1, D1, S_PERR, 32'h0, "perr_once");
    step();
    step();

    done = 1'b1;
  end

endmodule

// File: doc/mic1_regbank_memctl.md
Name: mic1_regbank_memctl

Overview:
- Parametrised successor to the MIC-1 datapath register block.
- Holds H, OPC, TOS, CPP, LV, SP, PC, MDR, MAR and MBR. Drives the A bus (always H) and a decoded B bus.
- Adds a fixed-latency RAM read/write port and a ROM fetch port, each with an in-flight counter, plus a stall output for the microsequencer.
- Sits between the control store (MIR fields) and the ALU/shifter and memories.

Parameters:
- DATA_W, 32, register and bus width.
- ADDR_W, 32, RAM/ROM address width; addresses are the low ADDR_W bits of MAR / PC.
- MBR_W, 8, MBR width; must be less than DATA_W.
- MEM_LAT, 1, cycles from command issue to data capture; legal range 1..15.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- c_bus  in  DATA_W  shifter output.
- c_en  in  9  write enables, bit 8..0 = H, OPC, TOS, CPP, LV, SP, PC, MDR, MAR.
- b_sel  in  4  B-bus source select.
- mem_rd  in  1  read command: RAM[MAR] into MDR.
- mem_wr  in  1  write command: MDR into RAM[MAR].
- mem_fetch  in  1  fetch command: ROM[PC] into MBR.
- ram_rdata  in  DATA_W  RAM read data.
- rom_rdata  in  MBR_W  ROM read data.
- a_bus  out  DATA_W  H, always driven.
- b_bus  out  DATA_W  selected source.
- mar, mdr, pc  out  DATA_W  register taps.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rd, ram_wr  out  1  one-cycle issue strobes.
- rom_addr  out  ADDR_W  ROM address.
- rom_rd  out  1  one-cycle issue strobe.
- stall  out  1  command refused this cycle.
- proto_err  out  1  registered one-cycle error pulse.
- perf_stall, perf_mem  out  32  performance counters (see Optional Feature).

Behaviour:
- Reset: all registers, counters and registered outputs go to 0. In-flight captures are discarded and never land.
- Register writes: at each edge, every register whose c_en bit is set loads c_bus. This is independent of memory activity, except for MDR (see priority below).
- b_sel decode (combinational, no tri-states):
  - 0 = MDR
  - 1 = PC
  - 2 = MBR sign-extended
  - 3 = MBR zero-extended
  - 4 = SP
  - 5 = LV
  - 6 = CPP
  - 7 = TOS
  - 8 = OPC
  - 9..15 = 0
- RAM port has one counter, rcnt (4 bits).
  - Port is busy while rcnt > 1.
  - Command accepted when not busy and exactly one of mem_rd/mem_wr is set.
  - On acceptance, the same cycle: ram_rd or ram_wr = 1, ram_addr = current MAR, ram_wdata = current MDR. rcnt loads MEM_LAT.
  - rcnt decrements each cycle while nonzero.
  - A read captures ram_rdata into MDR at the edge that ends the cycle with rcnt == 1. With MEM_LAT=1, a read issued in cycle k lands at the end of k+1.
  - A write frees the port on the same schedule and captures nothing.
  - A new command may issue in the cycle where rcnt == 1 (back-to-back).
- MDR priority: a read capture beats a c_en MDR write on the same edge.
- ROM port uses an identical counter, fcnt.
  - rom_rd = 1 and rom_addr = current PC on acceptance.
  - Capture loads rom_rdata into MBR.
  - The ROM port is independent of the RAM port; read and fetch may overlap.
- Stall: combinational, high when a command targets a busy port. A stalled command is not issued and has no side effects; the controller must hold it.
- mem_rd and mem_wr together: neither is issued; proto_err pulses the next cycle; stall is not asserted.
- MEM_LAT outside 1..15 is an elaboration error.

Optional Feature:
- Macro MIC1_REGBANK_PERF_EN.
- Defined:
  - perf_stall counts cycles with stall = 1.
  - perf_mem counts accepted RAM and ROM commands; it adds 2 when both are accepted in the same cycle.
  - Both counters wrap modulo 2^32 and clear on reset.
- Undefined: both outputs are constant 0 and no counter logic exists.

Test Plan:
- Reset mid-read: MEM_LAT=3, MAR=0x10, mem_rd at cycle 0, reset at cycle 1 -> MDR stays 0 and no capture occurs after reset releases.
- B-bus decode: MBR=0x80; b_sel=2 -> 0xFFFFFF80; b_sel=3 -> 0x00000080; b_sel=12 -> 0.
- Read latency, MEM_LAT=1: C writes MAR=0x20; next cycle mem_rd with ram_rdata=0xDEADBEEF -> ram_rd=1, ram_addr=0x20; MDR=0xDEADBEEF one cycle later. Repeat with MEM_LAT=4 -> MDR updates 4 cycles after issue.
- Stall and back-to-back, MEM_LAT=3: mem_rd, then mem_wr on the next cycle -> stall=1, ram_wr=0. mem_wr held -> issued in the cycle rcnt == 1, stall=0.
- MDR priority and overlap: a read landing on the same edge as c_en MDR with c_bus=0x1234 -> MDR = ram_rdata. A concurrent mem_fetch with PC=0x7, rom_rdata=0x5A -> MBR=0x5A, no stall.
- Protocol error and perf counters: mem_rd and mem_wr together -> proto_err pulses one cycle, no strobes. With MIC1_REGBANK_PERF_EN, after one read, one fetch and 2 stall cycles -> perf_mem=2, perf_stall=2.
